// File: rtl/cnn_pkg.sv
// rtl/cnn_pkg.sv - shared CNN front-end constants and window packing helper
package cnn_pkg;

  localparam int DATA_BITS   = 8;
  localparam int FILTER_SIZE = 5;
  localparam int IMG_W       = 28;
  localparam int IMG_H       = 28;
  localparam int WIN_BITS    = FILTER_SIZE * FILTER_SIZE * DATA_BITS;

  // Element (r,c) of a packed window lives at bits [win_idx(r,c)*DATA_BITS +: DATA_BITS]
  function automatic int win_idx(input int r, input int c);
    return r * FILTER_SIZE + c;
  endfunction

endpackage

// File: rtl/line_buffer.sv
// rtl/line_buffer.sv - one image-row delay, column addressed, read-before-write
module line_buffer #(
  parameter int DEPTH = 28,
  parameter int WIDTH = 8,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    addr,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  // Combinational read returns the value stored one row ago at this column
  assign rdata = mem[addr];

  // Contents are never reset; every entry is overwritten before it is read back
  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= wdata;
    end
  end

endmodule

// File: rtl/conv_window_buffer.sv
// rtl/conv_window_buffer.sv - raster pixel stream to sliding FILTER_SIZE x FILTER_SIZE window
module conv_window_buffer
  import cnn_pkg::*;
#(
  parameter int IMG_W       = cnn_pkg::IMG_W,
  parameter int IMG_H       = cnn_pkg::IMG_H,
  parameter int FILTER_SIZE = cnn_pkg::FILTER_SIZE,
  parameter int DATA_BITS   = cnn_pkg::DATA_BITS
) (
  input  logic                                     clk,
  input  logic                                     rst_n,
  input  logic                                     in_val,
  input  logic [DATA_BITS-1:0]                     data_in,
  output logic [FILTER_SIZE*FILTER_SIZE*DATA_BITS-1:0] window_out,
  output logic                                     out_val,
  output logic                                     frame_done
);

  localparam int CW  = $clog2(IMG_W);
  localparam int RW  = $clog2(IMG_H);
  localparam int NLB = FILTER_SIZE - 1;
  localparam int FS  = FILTER_SIZE;
  localparam int DB  = DATA_BITS;

  localparam logic [CW-1:0] COL_LAST  = CW'(IMG_W - 1);
  localparam logic [RW-1:0] ROW_LAST  = RW'(IMG_H - 1);
  localparam logic [CW-1:0] COL_FIRST = CW'(FILTER_SIZE - 1);
  localparam logic [RW-1:0] ROW_FIRST = RW'(FILTER_SIZE - 1);

  logic [CW-1:0] col;
  logic [RW-1:0] row;
  logic [DB-1:0] lb_rd [NLB];
  logic [DB-1:0] lb_wr [NLB];
  logic          win_pos;
  logic          last_pos;

  // A full window exists once FILTER_SIZE rows and columns of this frame are in
  assign win_pos  = (row >= ROW_FIRST) && (col >= COL_FIRST);
  assign last_pos = (row == ROW_LAST) && (col == COL_LAST);

  // Line buffers cascade: each one feeds the previous row's pixel to the next
  assign lb_wr[0] = data_in;
  for (genvar k = 1; k < NLB; k++) begin : g_lb_chain
    assign lb_wr[k] = lb_rd[k-1];
  end

  for (genvar k = 0; k < NLB; k++) begin : g_lb
    line_buffer #(
      .DEPTH (IMG_W),
      .WIDTH (DB),
      .AW    (CW)
    ) u_lb (
      .clk   (clk),
      .we    (in_val),
      .addr  (col),
      .wdata (lb_wr[k]),
      .rdata (lb_rd[k])
    );
  end

  // Raster position of the next accepted pixel
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      col <= '0;
      row <= '0;
    end else if (in_val) begin
      if (col == COL_LAST) begin
        col <= '0;
        row <= (row == ROW_LAST) ? '0 : row + 1'b1;
      end else begin
        col <= col + 1'b1;
      end
    end
  end

  // Shift the window left and load the newest column: oldest row at r=0, live pixel at the bottom
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      window_out <= '0;
    end else if (in_val) begin
      for (int r = 0; r < FS; r++) begin
        for (int c = 0; c < FS - 1; c++) begin
          window_out[(r*FS+c)*DB +: DB] <= window_out[(r*FS+c+1)*DB +: DB];
        end
      end
      window_out[((FS-1)*FS+FS-1)*DB +: DB] <= data_in;
      for (int k = 0; k < NLB; k++) begin
        window_out[((FS-2-k)*FS+FS-1)*DB +: DB] <= lb_rd[k];
      end
    end
  end

  // Valid and end-of-frame strobes line up with the window they describe
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_val    <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      out_val    <= in_val && win_pos;
      frame_done <= in_val && last_pos;
    end
  end

endmodule

// File: tb/tb_conv_window_buffer.sv
// tb/tb_conv_window_buffer.sv - scoreboard bench for conv_window_buffer
module tb_conv_window_buffer;
  import cnn_pkg::*;

  typedef logic [WIN_BITS-1:0] win_t;
  typedef struct {
    logic v;
    logic fd;
    win_t w;
    int   pix;
  } exp_t;

  logic                 clk = 1'b0;
  logic                 rst_n = 1'b0;
  logic                 in_val = 1'b0;
  logic [DATA_BITS-1:0] data_in = '0;
  win_t                 window_out;
  logic                 out_val;
  logic                 frame_done;

  always #5 clk = ~clk;

  conv_window_buffer #(
    .IMG_W       (IMG_W),
    .IMG_H       (IMG_H),
    .FILTER_SIZE (FILTER_SIZE),
    .DATA_BITS   (DATA_BITS)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_val     (in_val),
    .data_in    (data_in),
    .window_out (window_out),
    .out_val    (out_val),
    .frame_done (frame_done)
  );

  int   n_cmp = 0;
  int   n_bad = 0;
  exp_t expq[$];
  win_t obs[$];
  int   obs_pix[$];
  win_t ref1[$];
  int   fd_cnt = 0;
  logic last_acc = 1'b0;
  exp_t mon_e;
  logic [DATA_BITS-1:0] img [IMG_H][IMG_W];
  int   mrow = 0;
  int   mcol = 0;

  task automatic check(input string tag, input win_t got, input win_t exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [DATA_BITS-1:0] elem(input win_t w, input int r, input int c);
    return w[win_idx(r, c)*DATA_BITS +: DATA_BITS];
  endfunction

  always @(posedge clk) last_acc <= in_val & rst_n;

  always @(negedge clk) begin
    if (rst_n) begin
      if (last_acc) begin
        if (expq.size() == 0) begin
          check("exp_queue_empty", win_t'(1), win_t'(0));
        end else begin
          mon_e = expq.pop_front();
          check("out_val", win_t'(out_val), win_t'(mon_e.v));
          check("frame_done", win_t'(frame_done), win_t'(mon_e.fd));
          if (mon_e.v && out_val) begin
            check("window", window_out, mon_e.w);
          end
        end
      end else begin
        check("idle_out_val", win_t'(out_val), win_t'(0));
        check("idle_frame_done", win_t'(frame_done), win_t'(0));
      end
      if (out_val) begin
        obs.push_back(window_out);
        obs_pix.push_back(last_acc ? mon_e.pix : -1);
      end
      if (frame_done) fd_cnt++;
    end
  end

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
      in_val = 1'b0;
    end
  endtask

  task automatic send_pixel(input logic [DATA_BITS-1:0] pix);
    exp_t e;
    @(posedge clk);
    #2;
    in_val  = 1'b1;
    data_in = pix;
    img[mrow][mcol] = pix;
    e.v   = (mrow >= FILTER_SIZE - 1) && (mcol >= FILTER_SIZE - 1);
    e.fd  = (mrow == IMG_H - 1) && (mcol == IMG_W - 1);
    e.pix = mrow * IMG_W + mcol;
    e.w   = '0;
    if (e.v) begin
      for (int r = 0; r < FILTER_SIZE; r++)
        for (int c = 0; c < FILTER_SIZE; c++)
          e.w[win_idx(r, c)*DATA_BITS +: DATA_BITS] =
            img[mrow-(FILTER_SIZE-1)+r][mcol-(FILTER_SIZE-1)+c];
    end
    expq.push_back(e);
    if (mcol == IMG_W - 1) begin
      mcol = 0;
      mrow = (mrow == IMG_H - 1) ? 0 : mrow + 1;
    end else begin
      mcol = mcol + 1;
    end
  endtask

  // mode 0: ramp (r*IMG_W+c) mod 256; mode 1: constant 0xAA
  task automatic send_frame(input int mode, input int maxgap, input int npix);
    int n;
    logic [DATA_BITS-1:0] p;
    n = 0;
    for (int r = 0; r < IMG_H; r++) begin
      for (int c = 0; c < IMG_W; c++) begin
        if (n < npix) begin
          if (maxgap > 0) idle($urandom_range(0, maxgap));
          p = (mode == 0) ? DATA_BITS'((r * IMG_W + c) % 256) : 8'hAA;
          send_pixel(p);
          n++;
        end
      end
    end
  endtask

  task automatic do_reset();
    @(posedge clk);
    #2;
    in_val = 1'b0;
    rst_n  = 1'b0;
    mrow   = 0;
    mcol   = 0;
    expq.delete();
    @(posedge clk);
    @(negedge clk);
    check("rst_out_val", win_t'(out_val), win_t'(0));
    check("rst_frame_done", win_t'(frame_done), win_t'(0));
    check("rst_window", window_out, win_t'(0));
    @(posedge clk);
    #2;
    rst_n = 1'b1;
  endtask

  task automatic clear_obs();
    obs.delete();
    obs_pix.delete();
    fd_cnt = 0;
  endtask

  initial begin
    #600000;
    $display("FAIL watchdog: simulation time limit reached, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    do_reset();

    // Ramp frame, continuous
    clear_obs();
    send_frame(0, 0, IMG_W * IMG_H);
    idle(3);
    check("s1_count", win_t'(obs.size()), win_t'(576));
    check("s1_fd_count", win_t'(fd_cnt), win_t'(1));
    if (obs.size() == 576) begin
      check("s1_first_pix", win_t'(obs_pix[0]), win_t'(116));
      check("s1_e00", win_t'(elem(obs[0], 0, 0)), win_t'(8'h00));
      check("s1_e04", win_t'(elem(obs[0], 0, 4)), win_t'(8'h04));
      check("s1_e40", win_t'(elem(obs[0], 4, 0)), win_t'(8'h70));
      check("s1_e44", win_t'(elem(obs[0], 4, 4)), win_t'(8'h74));
      check("s2_last_e00", win_t'(elem(obs[575], 0, 0)), win_t'(8'h9B));
      check("s2_last_e44", win_t'(elem(obs[575], 4, 4)), win_t'(8'h0F));
      check("s5_pix_before_edge", win_t'(obs_pix[23]), win_t'(4 * 28 + 27));
      check("s5_pix_after_edge", win_t'(obs_pix[24]), win_t'(5 * 28 + 4));
      check("s5_e40", win_t'(elem(obs[24], 4, 0)), win_t'(8'h8C));
      check("s5_e00", win_t'(elem(obs[24], 0, 0)), win_t'(8'h1C));
    end
    ref1 = obs;

    // Same frame with random idle gaps
    clear_obs();
    send_frame(0, 3, IMG_W * IMG_H);
    idle(3);
    check("s3_count", win_t'(obs.size()), win_t'(576));
    if (obs.size() == ref1.size())
      foreach (obs[i]) check("s3_seq", obs[i], ref1[i]);

    // Ramp then constant frame, back to back
    clear_obs();
    send_frame(0, 0, IMG_W * IMG_H);
    send_frame(1, 0, IMG_W * IMG_H);
    idle(3);
    check("s4_count", win_t'(obs.size()), win_t'(1152));
    check("s4_fd_count", win_t'(fd_cnt), win_t'(2));
    if (obs.size() == 1152) begin
      check("s4_f1_last_pix", win_t'(obs_pix[575]), win_t'(783));
      check("s4_f2_first_pix", win_t'(obs_pix[576]), win_t'(116));
      check("s4_f2_first_win", obs[576], {25{8'hAA}});
    end

    // Reset mid-frame then a clean ramp frame
    send_frame(0, 0, 300);
    idle(2);
    do_reset();
    clear_obs();
    send_frame(0, 0, IMG_W * IMG_H);
    idle(3);
    check("s6_count", win_t'(obs.size()), win_t'(576));
    if (obs.size() == ref1.size())
      foreach (obs[i]) check("s6_seq", obs[i], ref1[i]);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
